// File: rtl/pattern_sequencer.sv
// pattern_sequencer: record/playback controller in front of a DEPTH x 4-bit SRAM.
// Record mode writes incoming pad codes to consecutive slots; play mode steps
// through the recorded slots, one step every TICKS_PER_STEP Tick pulses.
//
// Ports:
//   CLK, RST        clock, synchronous active-low reset
//   Key, KeyValid   pad code and its one-cycle strobe (recorded in RECORD only)
//   Rec/Play/Clr    one-cycle commands, honoured in IDLE only (Clr > Rec > Play)
//   Stop            leaves RECORD or PLAY
//   Tick            tempo strobe used in PLAY
//   Mem_Din/RW/Addr SRAM write data, write enable, address (registered)
//   Mem_Dout        combinational SRAM read of Mem_Addr
//   Note/NoteValid  played pad code and its one-cycle strobe
//   Length          number of recorded slots (4 bits: DEPTH = 16 reads back as 0)
//   Busy            controller not idle
module pattern_sequencer #(
    parameter int unsigned DEPTH          = 12,
    parameter int unsigned TICKS_PER_STEP = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] Key,
    input  logic       KeyValid,
    input  logic       Rec,
    input  logic       Play,
    input  logic       Clr,
    input  logic       Stop,
    input  logic       Tick,
    output logic [3:0] Mem_Din,
    output logic       Mem_RW,
    output logic [3:0] Mem_Addr,
    input  logic [3:0] Mem_Dout,
    output logic [3:0] Note,
    output logic       NoteValid,
    output logic [3:0] Length,
    output logic       Busy
);

    localparam int unsigned CW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
    localparam logic [3:0]    LAST_ADDR = 4'(DEPTH - 1);
    localparam logic [3:0]    FULL_LEN  = 4'(DEPTH);
    localparam logic [CW-1:0] CNT_LAST  = CW'(TICKS_PER_STEP - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECORD,
        ST_PLAY,
        ST_CLEAR
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] tick_cnt, tick_cnt_nxt;
    logic          stop_pend, stop_pend_nxt;
    logic [3:0]    din_nxt, addr_nxt, note_nxt, len_nxt;
    logic          rw_nxt, nv_nxt, busy_nxt;

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= ST_IDLE;
            tick_cnt  <= '0;
            stop_pend <= 1'b0;
            Mem_Din   <= 4'd0;
            Mem_RW    <= 1'b0;
            Mem_Addr  <= 4'd0;
            Note      <= 4'd0;
            NoteValid <= 1'b0;
            Length    <= 4'd0;
            Busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            tick_cnt  <= tick_cnt_nxt;
            stop_pend <= stop_pend_nxt;
            Mem_Din   <= din_nxt;
            Mem_RW    <= rw_nxt;
            Mem_Addr  <= addr_nxt;
            Note      <= note_nxt;
            NoteValid <= nv_nxt;
            Length    <= len_nxt;
            Busy      <= busy_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt     = state;
        tick_cnt_nxt  = tick_cnt;
        stop_pend_nxt = stop_pend;
        din_nxt       = Mem_Din;
        rw_nxt        = 1'b0;
        addr_nxt      = Mem_Addr;
        note_nxt      = Note;
        nv_nxt        = 1'b0;
        len_nxt       = Length;

        case (state)
            ST_IDLE: begin
                stop_pend_nxt = 1'b0;
                if (Clr) begin
                    state_nxt = ST_CLEAR;
                    rw_nxt    = 1'b1;
                    din_nxt   = 4'd0;
                    addr_nxt  = 4'd0;
                end else if (Rec) begin
                    state_nxt = ST_RECORD;
                    addr_nxt  = 4'd0;
                    len_nxt   = 4'd0;
                end else if (Play && (Length != 4'd0)) begin
                    state_nxt    = ST_PLAY;
                    addr_nxt     = 4'd0;
                    tick_cnt_nxt = '0;
                end
            end

            ST_RECORD: begin
                // A write driven this cycle completes at this edge.
                if (Mem_RW) begin
                    len_nxt  = Length + 4'd1;
                    addr_nxt = Mem_Addr + 4'd1;
                end
                if (Mem_RW && (Mem_Addr == LAST_ADDR)) begin
                    state_nxt     = ST_IDLE;
                    addr_nxt      = 4'd0;
                    len_nxt       = FULL_LEN;
                    stop_pend_nxt = 1'b0;
                end else if (stop_pend) begin
                    // Stop arrived with a key; that key's write just finished.
                    state_nxt     = ST_IDLE;
                    addr_nxt      = 4'd0;
                    stop_pend_nxt = 1'b0;
                end else if (KeyValid) begin
                    rw_nxt        = 1'b1;
                    din_nxt       = Key;
                    stop_pend_nxt = Stop;
                end else if (Stop) begin
                    state_nxt = ST_IDLE;
                    addr_nxt  = 4'd0;
                end
            end

            ST_PLAY: begin
                if (Stop) begin
                    state_nxt    = ST_IDLE;
                    addr_nxt     = 4'd0;
                    tick_cnt_nxt = '0;
                end else if (Tick) begin
                    if (tick_cnt == CNT_LAST) begin
                        tick_cnt_nxt = '0;
                        note_nxt     = Mem_Dout;
                        nv_nxt       = 1'b1;
                        addr_nxt     = (Mem_Addr == Length - 4'd1) ? 4'd0 : Mem_Addr + 4'd1;
                    end else begin
                        tick_cnt_nxt = tick_cnt + CW'(1);
                    end
                end
            end

            ST_CLEAR: begin
                if (Mem_Addr == LAST_ADDR) begin
                    state_nxt = ST_IDLE;
                    addr_nxt  = 4'd0;
                    len_nxt   = 4'd0;
                end else begin
                    rw_nxt   = 1'b1;
                    din_nxt  = 4'd0;
                    addr_nxt = Mem_Addr + 4'd1;
                end
            end

            default: state_nxt = ST_IDLE;
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
    end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Bench for pattern_sequencer: a behavioural SRAM, a table of per-cycle vectors
// for record/play, and hand-written sequences for clear, full record, stop and reset.
module tb_pattern_sequencer;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [3:0] Key = 4'd0;
    logic       KeyValid = 1'b0, Rec = 1'b0, Play = 1'b0, Clr = 1'b0, Stop = 1'b0, Tick = 1'b0;
    logic [3:0] Mem_Din, Mem_Addr, Mem_Dout, Note, Length;
    logic       Mem_RW, NoteValid, Busy;

    int checks = 0;
    int errors = 0;

    logic [3:0] sram [16];

    pattern_sequencer #(.DEPTH(12), .TICKS_PER_STEP(4)) dut (
        .CLK(CLK), .RST(RST), .Key(Key), .KeyValid(KeyValid),
        .Rec(Rec), .Play(Play), .Clr(Clr), .Stop(Stop), .Tick(Tick),
        .Mem_Din(Mem_Din), .Mem_RW(Mem_RW), .Mem_Addr(Mem_Addr), .Mem_Dout(Mem_Dout),
        .Note(Note), .NoteValid(NoteValid), .Length(Length), .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    // SRAM: synchronous write, combinational read.
    always @(posedge CLK) if (Mem_RW) sram[Mem_Addr] <= Mem_Din;
    assign Mem_Dout = sram[Mem_Addr];

    typedef struct {
        logic       rst;
        logic [3:0] key;
        logic       kv, rec, ply, clr, stp, tck;
        logic       rw;
        logic [3:0] addr, din;
        logic       nv;
        logic [3:0] note, len;
        logic       busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic [3:0] key,
                                input logic kv, input logic rec, input logic ply,
                                input logic clr, input logic stp, input logic tck,
                                input logic rw, input logic [3:0] addr, input logic [3:0] din,
                                input logic nv, input logic [3:0] note, input logic [3:0] len,
                                input logic busy);
        vec_t v;
        v.rst = rst; v.key = key; v.kv = kv; v.rec = rec; v.ply = ply;
        v.clr = clr; v.stp = stp; v.tck = tck;
        v.rw = rw; v.addr = addr; v.din = din; v.nv = nv;
        v.note = note; v.len = len; v.busy = busy;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic step(input logic rst, input logic [3:0] key, input logic kv,
                        input logic rec, input logic ply, input logic clr,
                        input logic stp, input logic tck);
        @(negedge CLK);
        RST = rst; Key = key; KeyValid = kv; Rec = rec; Play = ply;
        Clr = clr; Stop = stp; Tick = tck;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_step();
        step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] outs();
        return 32'({Mem_RW, Mem_Addr, Mem_Din, NoteValid, Note, Length, Busy});
    endfunction

    function automatic logic [31:0] pack_exp(input vec_t v);
        return 32'({v.rw, v.addr, v.din, v.nv, v.note, v.len, v.busy});
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) sram[i] = 4'hF;

        // Fields: rst key kv rec ply clr stp tck | rw addr din nv note len busy
        tbl.push_back(mk(0,4'h0,0,0,0,0,0,0, 0,4'd0,4'h0,0,4'h0,4'd0,0)); // reset
        tbl.push_back(mk(1,4'h0,0,0,0,0,0,0, 0,4'd0,4'h0,0,4'h0,4'd0,0));
        tbl.push_back(mk(1,4'h0,0,1,0,0,0,0, 0,4'd0,4'h0,0,4'h0,4'd0,1)); // Rec
        tbl.push_back(mk(1,4'h3,1,0,0,0,0,0, 1,4'd0,4'h3,0,4'h0,4'd0,1)); // key 3
        tbl.push_back(mk(1,4'h0,0,0,0,0,0,0, 0,4'd1,4'h3,0,4'h0,4'd1,1));
        tbl.push_back(mk(1,4'h0,0,0,0,0,0,0, 0,4'd1,4'h3,0,4'h0,4'd1,1));
        tbl.push_back(mk(1,4'h7,1,0,0,0,0,0, 1,4'd1,4'h7,0,4'h0,4'd1,1)); // key 7
        tbl.push_back(mk(1,4'h0,0,0,0,0,0,0, 0,4'd2,4'h7,0,4'h0,4'd2,1));
        tbl.push_back(mk(1,4'hA,1,0,0,0,0,0, 1,4'd2,4'hA,0,4'h0,4'd2,1)); // key A
        tbl.push_back(mk(1,4'h0,0,0,0,0,0,0, 0,4'd3,4'hA,0,4'h0,4'd3,1));
        tbl.push_back(mk(1,4'h0,0,0,0,0,1,0, 0,4'd0,4'hA,0,4'h0,4'd3,0)); // Stop
        tbl.push_back(mk(1,4'h0,0,0,1,0,0,0, 0,4'd0,4'hA,0,4'h0,4'd3,1)); // Play
        for (int r = 0; r < 4; r++) begin
            logic [3:0] nt;
            logic [3:0] na;
            nt = (r % 3 == 0) ? 4'h3 : (r % 3 == 1) ? 4'h7 : 4'hA;
            na = 4'((r + 1) % 3);
            for (int t = 0; t < 3; t++)
                tbl.push_back(mk(1,4'h0,0,0,0,0,0,1, 0,4'((r + 2) % 3 == 2 && r == 0 ? 0 : r % 3),4'hA,0,
                                 (r == 0) ? 4'h0 : ((r % 3 == 1) ? 4'h3 : (r % 3 == 2) ? 4'h7 : 4'hA),4'd3,1));
            tbl.push_back(mk(1,4'h0,0,0,0,0,0,1, 0,na,4'hA,1,nt,4'd3,1));
        end
        for (int t = 0; t < 3; t++)
            tbl.push_back(mk(1,4'h0,0,0,0,0,0,1, 0,4'd1,4'hA,0,4'h3,4'd3,1));
        tbl.push_back(mk(1,4'h0,0,0,0,0,1,1, 0,4'd0,4'hA,0,4'h3,4'd3,0)); // Stop + qualifying Tick
        tbl.push_back(mk(1,4'h0,0,0,0,0,1,0, 0,4'd0,4'hA,0,4'h3,4'd3,0)); // Stop in IDLE
        tbl.push_back(mk(1,4'h9,1,0,0,0,0,0, 0,4'd0,4'hA,0,4'h3,4'd3,0)); // KeyValid in IDLE

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].key, tbl[i].kv, tbl[i].rec, tbl[i].ply,
                 tbl[i].clr, tbl[i].stp, tbl[i].tck);
            check($sformatf("vec%0d", i), outs(), pack_exp(tbl[i]));
        end
        check("sram_rec3", 32'({sram[0], sram[1], sram[2], sram[3]}), 32'h37AF);

        // Clr and Rec together: clear wins, 12 zero-writes; commands ignored meanwhile.
        step(1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("clr_w0", 32'({Mem_RW, Mem_Addr, Mem_Din, Busy}), 32'({1'b1, 4'd0, 4'd0, 1'b1}));
        for (int i = 1; i < 12; i++) begin
            step(1'b1, 4'd0, 1'b0, i == 3, i == 4, i == 6, i == 5, 1'b0);
            check($sformatf("clr_w%0d", i), 32'({Mem_RW, Mem_Addr, Mem_Din, Busy}),
                  32'({1'b1, 4'(i), 4'd0, 1'b1}));
        end
        idle_step();
        check("clr_done", 32'({Mem_RW, Mem_Addr, Length, Busy}), 32'({1'b0, 4'd0, 4'd0, 1'b0}));
        for (int i = 0; i < 12; i++) check($sformatf("clr_sram%0d", i), 32'(sram[i]), 32'd0);

        // Play with Length 0 is ignored.
        step(1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("play_len0", 32'({Busy, NoteValid}), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            check("play_len0_tick", 32'({Busy, NoteValid, Mem_RW}), 32'd0);
        end

        // Full record: 13 back-to-back keys, the 13th is ignored.
        step(1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 4'(i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            check($sformatf("full_w%0d", i), 32'({Mem_RW, Mem_Addr, Mem_Din, Length, Busy}),
                  32'({1'b1, 4'(i), 4'(i), 4'(i), 1'b1}));
        end
        step(1'b1, 4'hC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("full_done", 32'({Mem_RW, Mem_Addr, Length, Busy}), 32'({1'b0, 4'd0, 4'd12, 1'b0}));
        idle_step();
        check("full_idle", 32'({Mem_RW, Mem_Addr, Length, Busy}), 32'({1'b0, 4'd0, 4'd12, 1'b0}));
        for (int i = 0; i < 12; i++) check($sformatf("full_sram%0d", i), 32'(sram[i]), 32'(i));

        // Stop with coincident key 5: key is written, then idle.
        step(1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("stopkey_w", 32'({Mem_RW, Mem_Addr, Mem_Din, Length, Busy}),
              32'({1'b1, 4'd0, 4'h5, 4'd0, 1'b1}));
        idle_step();
        check("stopkey_done", 32'({Mem_RW, Mem_Addr, Length, Busy}), 32'({1'b0, 4'd0, 4'd1, 1'b0}));
        check("stopkey_sram", 32'(sram[0]), 32'h5);

        // Reset during a record write cycle abandons it.
        step(1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'h9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_pre", 32'({Mem_RW, Busy}), 32'({1'b1, 1'b1}));
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_mid", 32'({Mem_RW, Mem_Addr, Length, Busy, NoteValid}), 32'd0);
        idle_step();
        check("rst_after", 32'({Mem_RW, Mem_Addr, Length, Busy}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
